sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO. Next-generation buffer for the SAD full-search datapath
//  (pixel/candidate streams between fetch and SAD units).
//  Generalises width/depth and adds programmable almost-full/almost-empty flags, flush and
//  registered read-valid.
//  Simultaneous read/write is exact at full and empty.
// PARAMETERS
//  DATA_W    8    data word width, bits
//  DEPTH     256  number of entries; power of two, >=2
//  AF_THRESH 252  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH 4    almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  AW = $clog2(DEPTH), derived localparam; pointers are AW bits, count is AW+1 bits
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  rst          in   1         synchronous, active-high reset
//  flush        in   1         synchronous clear of contents (pointers/count only)
//  wr_en        in   1         write request
//  wr_data      in   DATA_W    write data
//  rd_en        in   1         read request
//  rd_data      out  DATA_W    registered read data
//  rd_valid     out  1         rd_data updated this cycle (1-cycle pulse per accepted read)
//  full         out  1         count == DEPTH
//  empty        out  1         count == 0
//  almost_full  out  1         count >= AF_THRESH
//  almost_empty out  1         count <= AE_THRESH
//  count        out  AW+1      current occupancy, 0..DEPTH
//  ovf          out  1         sticky overflow error (see CONFIGURATION)
//  udf          out  1         sticky underflow error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1):
//   - wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0, ovf=udf=0.
//   - Memory contents not cleared; rst overrides flush/wr/rd.
//  Acceptance, evaluated on registered state:
//   - rd_acc = rd_en & !empty
//   - wr_acc = wr_en & (!full | rd_en)
//  Full + wr_en + rd_en:
//   - Both accepted; read returns the oldest word (read-before-write on the shared slot).
//   - count stays DEPTH.
//  Empty + wr_en + rd_en:
//   - Write accepted, read rejected (no fall-through); count becomes 1, rd_valid stays 0.
//  Next-state update:
//   - count_next = count + wr_acc - rd_acc; never exceeds DEPTH, never below 0.
//   - Pointers increment on acceptance, wrap modulo DEPTH (AW-bit natural rollover).
//  Read latency:
//   - rd_acc in cycle N -> rd_data = mem[rd_ptr] and rd_valid=1 in cycle N+1.
//   - rd_data holds its last value when there is no read; rd_valid=0 otherwise.
//  Flags:
//   - full/empty/almost_* are combinational decodes of the count register.
//   - They reflect state after the last edge (no look-ahead).
//  flush=1 (rst=0):
//   - Next edge: pointers=0, count=0, rd_valid=0; wr/rd in that cycle ignored.
//   - rd_data holds; ovf/udf hold.
//  Reset mid-operation: same as reset; any in-flight read is dropped, rd_valid=0 next cycle.
// CONFIGURATION
//  Macro FIFO_ERR_EN.
//  Defined:
//   - ovf set when wr_en & !wr_acc; udf set when rd_en & empty.
//   - Both sticky until rst.
//  Undefined:
//   - ovf and udf tied to 0; detection logic not built.
//   - Ports remain so instantiations are unchanged.
//  Data path and flags are identical either way.
// TESTING (DEPTH=16, DATA_W=8, AF_THRESH=14, AE_THRESH=2)
//  1. rst, write 0x00..0x0F, then read 16 -> rd_data 0x00..0x0F in order, each 1 cycle after rd_en.
//     full=1 after the 16th write; empty=1 after the 16th read.
//  2. Fill 16, hold wr_en+rd_en 20 cycles with incrementing data -> count stays 16, full stays 1.
//     Read order continuous, no loss or duplication; pointers wrap.
//  3. Empty, wr_en+rd_en with 0xA5 -> count=1, rd_valid=0.
//     Next cycle rd_en -> rd_data=0xA5, rd_valid=1.
//  4. Write 1,2,3 -> almost_empty 1,1,0; continue to 14 -> almost_full=1 at count 14.
//     At 13 -> almost_full=0.
//  5. count=9, flush -> count=0, empty=1, rd_data unchanged.
//     Assert rst while a read is in flight -> rd_valid=0 and all outputs at reset values.
//  6. FIFO_ERR_EN: wr_en at full without rd_en -> ovf=1, contents intact.
//     rd_en at empty -> udf=1; both stay 1 through flush and clear only on rst.
//     Without the macro both stay 0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, programmable almost flags and flush.
// Optional sticky overflow/underflow detection is built only when FIFO_ERR_EN is defined.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int AF_THRESH = 252,
  parameter int AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_next;
  logic              wr_acc;
  logic              rd_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A write at full is only taken when a read frees the slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      count    <= count_next;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  // Storage is not reset; the non-blocking read above returns the old word when both hit one slot.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (!flush) begin
      if (wr_en && !wr_acc) ovf <= 1'b1;
      if (rd_en && empty)   udf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
